radix_2_pipe: RTL and testbench
===============================

Name: radix_2_pipe

Overview:
Pipelined, parametrised successor to the combinational radix-2 NTT/INTT butterfly.
- NTT mode uses a Cooley-Tukey butterfly; INTT mode uses a Gentleman-Sande butterfly.
- Has a fixed latency, accepts one butterfly per cycle, and uses a valid/ready handshake on both sides.
- The mode is carried per transaction, so NTT and INTT operations may be interleaved in flight.
- Sits between the coefficient memory read port and the write-back path of the NTT engine.

Parameters:
- WIDTH, 14, coefficient/twiddle bit width; MODULUS must be less than 2^WIDTH.
- MODULUS, 12289, prime modulus q.
- MULT_STAGES, 3, register stages inside the modular multiplier (allowed range 1 to 4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input this cycle.
- in_a  in  WIDTH  first coefficient; must be less than MODULUS.
- in_b  in  WIDTH  second coefficient; must be less than MODULUS.
- in_twiddle  in  WIDTH  twiddle factor; must be less than MODULUS.
- in_mode  in  1  0 = NTT (CT), 1 = INTT (GS).
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_a  out  WIDTH  first result.
- out_b  out  WIDTH  second result.
- out_mode  out  1  mode of the emitted transaction.

Behaviour:
- Arithmetic, all mod q:
  - NTT: out_a = a + b·w, out_b = a − b·w.
  - INTT: out_a = a + b, out_b = (a − b)·w.
- Every result is fully reduced to the range [0, q).
- Modular add/sub: one conditional correction each. The sum uses WIDTH+1 internal bits; the difference adds q when it is negative.
- Modular multiply: 2·WIDTH-bit product followed by reduction. The reduction method is free to choose, but it must be exact for all operands below q.
- Pipeline, L = MULT_STAGES + 2 stages, each holding its own valid and mode bit:
  - S0 (pre-add): INTT registers a+b and a−b; NTT passes a and b through.
  - M1..Mn (multiply): operand is b for NTT and (a−b) for INTT. The other lane is delayed alongside it.
  - SF (post-add): NTT registers a+p and a−p; INTT registers the sum and the product p. SF drives the outputs directly from registers.
- Latency: exactly L cycles from an input handshake to out_valid when there is no stall. Default L = 5.
- Handshake, global stall scheme:
  - advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 0, every stage holds. out_a, out_b and out_mode stay stable while out_valid is high and out_ready is low.
  - When advance = 1, every stage shifts. A cycle with in_valid = 0 inserts a bubble. Bubbles are not collapsed.
  - Throughput is one transaction per cycle while out_ready stays high. Order is preserved.
- Mixed modes: any in_mode sequence is legal back-to-back, because each stage acts on its own mode bit.
- Reset:
  - All valid bits clear, and out_a, out_b and out_mode go to 0. in_ready reads 1 while reset is deasserted and the pipeline is empty.
  - Reset mid-stream discards all in-flight transactions; none of them is ever emitted.
- Out-of-range inputs (≥ q): the output value is unspecified, but the handshake and latency are unaffected.

Optional Feature:
- Macro: RADIX_2_HALF_SCALE_EN.
- Defined: in INTT mode, SF multiplies both outputs by 2⁻¹ mod q using (x even ? x>>1 : (x+q)>>1). This is combinational before the SF register, so latency is unchanged. NTT mode is unaffected.
- Undefined: INTT outputs are unscaled. The final n⁻¹ scaling is then applied externally.

Decomposition:
- Shared header radix_2_pipe_parameter.vh holds:
  - defaults for WIDTH, MODULUS and MULT_STAGES;
  - the mode encodings MODE_NTT = 0 and MODE_INTT = 1;
  - the derived constant INV2 = (MODULUS+1)/2;
  - any reduction constants (e.g. the Barrett factor).
- One sub-module: mod_mult_pipe.
  - Pipelined modular multiplier with MULT_STAGES stages.
  - Has a stage-enable input tied to advance.
  - Carries side-band lanes (other operand, mode, valid) so that they stay aligned with the product.

Test Plan:
- NTT, a=5, b=3, w=7, out_ready=1 -> after 5 cycles out_a=26, out_b=12273, out_mode=0.
- INTT, a=5, b=3, w=7 -> out_a=8, out_b=14. With RADIX_2_HALF_SCALE_EN defined -> out_a=4, out_b=7.
- Wrap-around cases:
  - NTT a=12288, b=1, w=1 -> out_a=0, out_b=12287.
  - INTT a=0, b=1, w=12288 -> out_b=1.
- Alternating NTT/INTT stream of 8 random vectors -> results match the reference model in order, with each out_mode matching its input.
- Backpressure: 8 back-to-back inputs with out_ready held low for 3 cycles mid-stream -> in_ready=0 during the hold, outputs stay stable, no loss or duplication, all 8 delivered in order.
- Assert rst with 3 transactions in flight -> out_valid=0 immediately and outputs read 0. After release, a new input appears after exactly 5 cycles and no pre-reset data is ever emitted.

Source files
------------

// File: rtl/radix_2_pipe_pkg.sv
// Shared constants for the pipelined radix-2 NTT/INTT butterfly:
// parameter defaults, mode encodings, the 1/2 mod q constant and the
// Barrett reduction factor.
package radix_2_pipe_pkg;

    localparam int DEF_WIDTH       = 14;
    localparam int DEF_MODULUS     = 12289;
    localparam int DEF_MULT_STAGES = 3;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    // 2^-1 mod q for an odd prime q
    localparam int DEF_INV2 = (DEF_MODULUS + 1) / 2;

    // Barrett factor floor(2^(2*width) / modulus); exact for products of two
    // operands below the modulus after at most two corrective subtractions.
    function automatic longint unsigned barrett_factor(input int width, input int modulus);
        return (64'd1 << (2 * width)) / 64'(modulus);
    endfunction

    localparam longint unsigned DEF_BARRETT_M = barrett_factor(DEF_WIDTH, DEF_MODULUS);

endpackage

// File: rtl/radix_2_pipe_mod_mult_pipe.sv
// Pipelined modular multiplier (res = x * w mod MODULUS) with MULT_STAGES
// register stages (1..4). A side-band lane (other operand, mode, valid)
// travels with the product so everything leaves aligned. All stages hold
// while en is low.
module mod_mult_pipe
    import radix_2_pipe_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MODULUS     = DEF_MODULUS,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_w,
    input  logic [WIDTH-1:0] op_side,
    input  logic             op_mode,
    input  logic             op_vld,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_side,
    output logic             res_mode,
    output logic             res_vld
);

    localparam int PW = 2 * WIDTH;
    localparam int TW = 2 * PW + 1;
    localparam logic [TW-1:0] BARRETT_M = TW'(barrett_factor(WIDTH, MODULUS));
    localparam logic [PW-1:0] Q_PW      = PW'(MODULUS);

    // Barrett reduction: quotient estimate is low by at most 2, so the
    // remainder is below 3q and two conditional subtractions finish it.
    function automatic logic [WIDTH-1:0] barrett_reduce(input logic [PW-1:0] p);
        logic [TW-1:0] t;
        logic [PW-1:0] qe;
        logic [PW-1:0] r;
        t  = TW'(p) * BARRETT_M;
        qe = PW'(t >> PW);
        r  = p - qe * Q_PW;
        if (r >= Q_PW) r = r - Q_PW;
        if (r >= Q_PW) r = r - Q_PW;
        return WIDTH'(r);
    endfunction

    logic [WIDTH-1:0] side_p [MULT_STAGES];
    logic             mode_p [MULT_STAGES];
    logic             vld_p  [MULT_STAGES];

    // Valid lane shifts with the product; cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MULT_STAGES; i++) vld_p[i] <= 1'b0;
        end else if (en) begin
            vld_p[0] <= op_vld;
            for (int i = 1; i < MULT_STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Side operand and mode lanes shift with the product
    always_ff @(posedge clk) begin
        if (en) begin
            side_p[0] <= op_side;
            mode_p[0] <= op_mode;
            for (int i = 1; i < MULT_STAGES; i++) begin
                side_p[i] <= side_p[i-1];
                mode_p[i] <= mode_p[i-1];
            end
        end
    end

    generate
        if (MULT_STAGES == 1) begin : g_single
            logic [WIDTH-1:0] red_p0;
            // Multiply and reduce within the single stage
            always_ff @(posedge clk) begin
                if (en) red_p0 <= barrett_reduce(PW'(op_x) * PW'(op_w));
            end
            assign res = red_p0;
        end else begin : g_multi
            logic [PW-1:0]    prod_p0;
            logic [WIDTH-1:0] red_p [MULT_STAGES-1];
            // Raw product first, reduction in the second stage, then delay
            always_ff @(posedge clk) begin
                if (en) begin
                    prod_p0  <= PW'(op_x) * PW'(op_w);
                    red_p[0] <= barrett_reduce(prod_p0);
                    for (int i = 1; i < MULT_STAGES - 1; i++) red_p[i] <= red_p[i-1];
                end
            end
            assign res = red_p[MULT_STAGES-2];
        end
    endgenerate

    assign res_side = side_p[MULT_STAGES-1];
    assign res_mode = mode_p[MULT_STAGES-1];
    assign res_vld  = vld_p[MULT_STAGES-1];

endmodule

// File: rtl/radix_2_pipe.sv
// Pipelined radix-2 butterfly: NTT mode (Cooley-Tukey) and INTT mode
// (Gentleman-Sande), mode carried per transaction. Latency MULT_STAGES+2
// with a single global stall (advance) shared by every stage.
// Optional macro RADIX_2_HALF_SCALE_EN: INTT outputs are multiplied by
// 2^-1 mod q before the final register.
module radix_2_pipe
    import radix_2_pipe_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MODULUS     = DEF_MODULUS,
    parameter int MULT_STAGES = DEF_MULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_twiddle,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_mode
);

    localparam logic [WIDTH:0] Q_EXT = (WIDTH + 1)'(MODULUS);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_EXT) s = s - Q_EXT;
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [WIDTH+1:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        if (d < 0) d = d + $signed({1'b0, Q_EXT});
        return WIDTH'(d);
    endfunction

`ifdef RADIX_2_HALF_SCALE_EN
    // x * 2^-1 mod q: odd values become even by adding q before halving
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] t;
        t = x[0] ? ({1'b0, x} + Q_EXT) : {1'b0, x};
        return WIDTH'(t >> 1);
    endfunction
`endif

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic             vld_p0;
    logic             mode_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] w_p0;

    // S0 valid; a bubble enters whenever in_valid is low on an advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p0 <= 1'b0;
        else if (advance) vld_p0 <= in_valid;
    end

    // S0 pre-add: INTT forms a+b / a-b, NTT passes a and b through
    always_ff @(posedge clk) begin
        if (advance) begin
            mode_p0 <= in_mode;
            w_p0    <= in_twiddle;
            if (in_mode == MODE_INTT) begin
                a_p0 <= mod_add(in_a, in_b);
                b_p0 <= mod_sub(in_a, in_b);
            end else begin
                a_p0 <= in_a;
                b_p0 <= in_b;
            end
        end
    end

    logic [WIDTH-1:0] prod_m;
    logic [WIDTH-1:0] side_m;
    logic             mode_m;
    logic             vld_m;

    mod_mult_pipe #(
        .WIDTH       (WIDTH),
        .MODULUS     (MODULUS),
        .MULT_STAGES (MULT_STAGES)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .en       (advance),
        .op_x     (b_p0),
        .op_w     (w_p0),
        .op_side  (a_p0),
        .op_mode  (mode_p0),
        .op_vld   (vld_p0),
        .res      (prod_m),
        .res_side (side_m),
        .res_mode (mode_m),
        .res_vld  (vld_m)
    );

    logic [WIDTH-1:0] sf_a;
    logic [WIDTH-1:0] sf_b;

    // SF post-add: NTT forms a+p / a-p, INTT forwards the sum and product
    always_comb begin
        sf_a = mod_add(side_m, prod_m);
        sf_b = mod_sub(side_m, prod_m);
        if (mode_m == MODE_INTT) begin
`ifdef RADIX_2_HALF_SCALE_EN
            sf_a = half_mod(side_m);
            sf_b = half_mod(prod_m);
`else
            sf_a = side_m;
            sf_b = prod_m;
`endif
        end
    end

    // SF register drives the outputs directly; held during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_mode  <= 1'b0;
        end else if (advance) begin
            out_valid <= vld_m;
            out_a     <= sf_a;
            out_b     <= sf_b;
            out_mode  <= mode_m;
        end
    end

endmodule

// File: tb/tb_radix_2_pipe.sv
// Self-checking bench for radix_2_pipe: directed butterflies with literal
// expectations, a mod-q reference model with an in-order expectation queue,
// backpressure and mid-stream reset.
`timescale 1ns/1ps
module tb_radix_2_pipe;

    localparam int Q = 12289;
    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_a;
    logic [13:0] in_b;
    logic [13:0] in_twiddle;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_a;
    logic [13:0] out_b;
    logic        out_mode;

    radix_2_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_twiddle (in_twiddle),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_mode   (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int mode;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   accepted  = 0;
    int   delivered = 0;

    function automatic int modq(input longint x);
        longint r;
        r = x % Q;
        if (r < 0) r = r + Q;
        return int'(r);
    endfunction

`ifdef RADIX_2_HALF_SCALE_EN
    function automatic int half(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction
`endif

    function automatic exp_t model(input int a, input int b, input int w, input int m);
        exp_t e;
        e.mode = m;
        if (m == 0) begin
            e.a = modq(longint'(a) + longint'(b) * w);
            e.b = modq(longint'(a) - longint'(b) * w);
        end else begin
            e.a = modq(longint'(a) + b);
            e.b = modq(longint'(a - b) * w);
`ifdef RADIX_2_HALF_SCALE_EN
            e.a = half(e.a);
            e.b = half(e.b);
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Compare process: every output beat is checked against the queue head
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_valid", int'(out_valid), 0);
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                check("out_a", int'(out_a), exp_q[0].a);
                check("out_b", int'(out_b), exp_q[0].b);
                check("out_mode", int'(out_mode), exp_q[0].mode);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    // Present one transaction (called at posedge+1), wait for acceptance
    task automatic send(input int a, input int b, input int w, input int m);
        int guard;
        guard      = 0;
        in_a       = 14'(a);
        in_b       = 14'(b);
        in_twiddle = 14'(w);
        in_mode    = m[0];
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(a, b, w, m));
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges from the presenting cycle until out_valid
    task automatic wait_out(input string name);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, n, L);
    endtask

    task automatic one(input string name, input int a, input int b, input int w, input int m,
                       input int ea, input int eb);
        send(a, b, w, m);
        wait_out({name, "_latency"});
        check({name, "_a"}, int'(out_a), ea);
        check({name, "_b"}, int'(out_b), eb);
        check({name, "_mode"}, int'(out_mode), m);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_remaining"}, exp_q.size(), 0);
        check({name, "_count"}, delivered, accepted);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   ha;
        int   hb;
        int   hm;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_twiddle = '0;
        in_mode    = 1'b0;
        out_ready  = 1'b1;

        // Model pinned by hand-computed values
        e = model(5, 3, 7, 0);
        check("model_ntt_a", e.a, 26);
        check("model_ntt_b", e.b, 12273);
        e = model(12288, 1, 1, 0);
        check("model_wrap_ntt_a", e.a, 0);
        check("model_wrap_ntt_b", e.b, 12287);
`ifdef RADIX_2_HALF_SCALE_EN
        e = model(5, 3, 7, 1);
        check("model_intt_a", e.a, 4);
        check("model_intt_b", e.b, 7);
        e = model(0, 1, 12288, 1);
        check("model_wrap_intt_b", e.b, 6145);
`else
        e = model(5, 3, 7, 1);
        check("model_intt_a", e.a, 8);
        check("model_intt_b", e.b, 14);
        e = model(0, 1, 12288, 1);
        check("model_wrap_intt_b", e.b, 1);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_a", int'(out_a), 0);
        check("reset_out_b", int'(out_b), 0);
        check("reset_out_mode", int'(out_mode), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Directed butterflies
        one("ntt_basic", 5, 3, 7, 0, 26, 12273);
`ifdef RADIX_2_HALF_SCALE_EN
        one("intt_basic", 5, 3, 7, 1, 4, 7);
        one("intt_wrap", 0, 1, 12288, 1, 6145, 6145);
`else
        one("intt_basic", 5, 3, 7, 1, 8, 14);
        one("intt_wrap", 0, 1, 12288, 1, 1, 1);
`endif
        one("ntt_wrap", 12288, 1, 1, 0, 0, 12287);
        drain("directed");

        // Alternating NTT/INTT stream, back to back
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
                 int'($urandom_range(0, Q - 1)), i % 2);
        end
        drain("alternating");

        // Backpressure: out_ready low for 3 cycles while 8 inputs stream in
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
                         int'($urandom_range(0, Q - 1)), int'($urandom_range(0, 1)));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("hold_out_valid", int'(out_valid), 1);
                check("hold_in_ready", int'(in_ready), 0);
                ha = int'(out_a);
                hb = int'(out_b);
                hm = int'(out_mode);
                repeat (2) begin
                    @(negedge clk);
                    check("hold_in_ready", int'(in_ready), 0);
                    check("hold_stable_a", int'(out_a), ha);
                    check("hold_stable_b", int'(out_b), hb);
                    check("hold_stable_mode", int'(out_mode), hm);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset with three transactions in flight
        send(5, 3, 7, 0);
        send(100, 200, 300, 1);
        send(1, 2, 3, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        accepted = delivered;
        #1;
        check("rst_now_out_valid", int'(out_valid), 0);
        check("rst_now_out_a", int'(out_a), 0);
        check("rst_now_out_b", int'(out_b), 0);
        check("rst_now_out_mode", int'(out_mode), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        one("post_rst", 5, 3, 7, 0, 26, 12273);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
